// File: rtl/mux_8_1_scan_ctrl.sv
// Scan sequencer for the 8:1 mux: drives s, waits out the settle time, then
// offers the captured y with its channel index on a valid/ready stream.
//
// state  | meaning
// IDLE   | waiting for start; s holds the last channel scanned
// SETTLE | s applied, settle down-counter running toward zero
// WAIT   | sample presented, holding until the consumer accepts it
module mux_8_1_scan_ctrl #(
  parameter int WIDTH         = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             continuous,
  input  logic [7:0]       ch_mask,
  output logic [2:0]       s,
  input  logic [WIDTH-1:0] y_in,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_ch,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SETTLE, WAIT} state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  state_t           state, state_nxt;
  logic [7:0]       mask_r, mask_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic [2:0]       s_nxt, ch_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic             valid_nxt, busy_nxt, done_nxt;
  logic [3:0]       first_start, next_up, first_wrap;

  // Returns {found, index} of the lowest set bit of m at or above lo.
  function automatic logic [3:0] first_set(input logic [7:0] m, input logic [3:0] lo);
    logic [3:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (4'(i) >= lo && m[i]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mask_r    <= '0;
      cnt       <= '0;
      s         <= '0;
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      mask_r    <= mask_nxt;
      cnt       <= cnt_nxt;
      s         <= s_nxt;
      out_data  <= data_nxt;
      out_ch    <= ch_nxt;
      out_valid <= valid_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  always_comb begin
    first_start = first_set(ch_mask, 4'd0);
    next_up     = first_set(mask_r, {1'b0, s} + 4'd1);
    first_wrap  = first_set(mask_r, 4'd0);

    state_nxt = state;
    mask_nxt  = mask_r;
    cnt_nxt   = cnt;
    s_nxt     = s;
    data_nxt  = out_data;
    ch_nxt    = out_ch;
    valid_nxt = out_valid;
    busy_nxt  = busy;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if (first_start[3]) begin
            mask_nxt  = ch_mask;
            s_nxt     = first_start[2:0];
            cnt_nxt   = SETTLE_INIT;
            busy_nxt  = 1'b1;
            state_nxt = SETTLE;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      SETTLE: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          data_nxt  = y_in;
          ch_nxt    = s;
          valid_nxt = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (out_ready) begin
          valid_nxt = 1'b0;
          if (next_up[3]) begin
            s_nxt     = next_up[2:0];
            cnt_nxt   = SETTLE_INIT;
            state_nxt = SETTLE;
          end else if (continuous && first_wrap[3]) begin
            // Even a single-channel mask rewrites s and re-settles each pass.
            s_nxt     = first_wrap[2:0];
            cnt_nxt   = SETTLE_INIT;
            state_nxt = SETTLE;
          end else begin
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux_8_1_scan_ctrl.sv
// Bench for mux_8_1_scan_ctrl: mux modelled as d_i = i, a channel-list model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_mux_8_1_scan_ctrl;
  localparam int S = 2;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         continuous = 1'b0;
  logic         out_ready = 1'b0;
  logic [7:0]   ch_mask = 8'h00;
  logic [2:0]   s, out_ch;
  logic [W-1:0] y_in, out_data;
  logic         out_valid, busy, done;
  logic [W-1:0] d [8];

  mux_8_1_scan_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous),
    .ch_mask(ch_mask), .s(s), .y_in(y_in), .out_data(out_data),
    .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  assign y_in = d[s];
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int tot_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Model: remaining channels of the current pass, plus settle timing.
  bit         m_busy, m_valid, m_done;
  int         m_ch, m_wait;
  logic [7:0] m_mask;
  int         m_list[$];
  int         hs_log[$];
  int         vr_cyc[$];
  int         done_cnt = 0;
  int         cyc = 0;
  bit         prev_valid;

  task automatic fill_list();
    m_list.delete();
    for (int i = 0; i < 8; i++) if (m_mask[i]) m_list.push_back(i);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_s", int'(s), 0);
      m_busy = 0; m_valid = 0; m_done = 0; m_ch = 0; m_wait = 0;
      m_mask = '0; m_list.delete(); prev_valid = 0;
    end else begin
      chk("valid", int'(out_valid), int'(m_valid));
      chk("busy", int'(busy), int'(m_busy));
      chk("done", int'(done), int'(m_done));
      chk("s", int'(s), m_ch);
      chk("done_with_valid", int'(done & out_valid), 0);
      if (m_valid) begin
        chk("out_ch", int'(out_ch), m_ch);
        chk("out_data", int'(out_data), int'(d[m_ch]));
      end
      if (out_valid && !prev_valid) vr_cyc.push_back(cyc);
      if (done) done_cnt++;
      if (out_valid && out_ready) hs_log.push_back(int'(out_ch));
      prev_valid = out_valid;

      // Predict the state after the coming rising edge.
      m_done = 0;
      if (!m_busy) begin
        if (start) begin
          if (ch_mask != 8'h00) begin
            m_mask = ch_mask;
            fill_list();
            m_ch = m_list.pop_front();
            m_busy = 1;
            m_wait = S;
          end else begin
            m_done = 1;
          end
        end
      end else if (m_valid) begin
        if (out_ready) begin
          m_valid = 0;
          if (m_list.size() == 0 && continuous) fill_list();
          if (m_list.size() != 0) begin
            m_ch = m_list.pop_front();
            m_wait = S;
          end else begin
            m_busy = 0;
            m_done = 1;
          end
        end
      end else begin
        m_wait--;
        if (m_wait == 0) m_valid = 1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_start(input logic [7:0] mask);
    ch_mask = mask;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0, k;
    d0 = done_cnt;
    k = 0;
    while (done_cnt == d0 && k < budget) begin
      tick(1);
      k++;
    end
    chk({name, "_done_seen"}, done_cnt - d0, 1);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int k;
    k = 0;
    while (!out_valid && k < budget) begin
      tick(1);
      k++;
    end
    chk({name, "_valid_seen"}, int'(out_valid), 1);
  endtask

  task automatic check_log(input string name, input int e[$]);
    chk({name, "_count"}, hs_log.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      chk({name, "_ch"}, (i < hs_log.size()) ? hs_log[i] : -1, e[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e[$];
    int d0;
    int v0;
    int exp_ch[3];
    for (int i = 0; i < 8; i++) d[i] = W'(i);

    // Full scan
    tick(3);
    reset = 1'b0;
    tick(2);
    chk("idle_busy", int'(busy), 0);
    out_ready = 1'b1;
    hs_log.delete(); vr_cyc.delete();
    d0 = done_cnt;
    pulse_start(8'hFF);
    wait_done("full", 100);
    e = '{0, 1, 2, 3, 4, 5, 6, 7};
    check_log("full", e);
    chk("full_valid_count", vr_cyc.size(), 8);
    for (int i = 1; i < vr_cyc.size(); i++)
      chk("full_gap", vr_cyc[i] - vr_cyc[i-1], 3);
    tick(1);
    chk("full_busy_after", int'(busy), 0);
    chk("full_done_once", done_cnt - d0, 1);

    // Sparse mask with 5-cycle stalls
    out_ready = 1'b0;
    hs_log.delete();
    exp_ch = '{2, 5, 7};
    pulse_start(8'b1010_0100);
    for (int n = 0; n < 3; n++) begin
      wait_valid("sparse", 50);
      tick(5);
      chk("stall_ch", int'(out_ch), exp_ch[n]);
      chk("stall_data", int'(out_data), exp_ch[n]);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
    end
    wait_done("sparse", 50);
    e = '{2, 5, 7};
    check_log("sparse", e);

    // Continuous wrap, then end after the second ch7 sample
    hs_log.delete();
    out_ready = 1'b1;
    continuous = 1'b1;
    pulse_start(8'b1000_0001);
    for (int k = 0; k < 200; k++) begin
      tick(1);
      if (hs_log.size() == 3 && out_valid) begin
        continuous = 1'b0;
        break;
      end
    end
    wait_done("cont", 50);
    e = '{0, 7, 0, 7};
    check_log("cont", e);

    // Empty mask
    tick(2);
    d0 = done_cnt;
    v0 = vr_cyc.size();
    pulse_start(8'h00);
    chk("empty_done", int'(done), 1);
    chk("empty_busy", int'(busy), 0);
    tick(2);
    chk("empty_done_once", done_cnt - d0, 1);
    chk("empty_no_valid", vr_cyc.size(), v0);

    // Start and mask change while busy are ignored
    hs_log.delete();
    pulse_start(8'b0001_0010);
    tick(2);
    pulse_start(8'hFF);
    ch_mask = 8'b0000_0001;
    wait_done("busy_start", 50);
    e = '{1, 4};
    check_log("busy_start", e);

    // Async reset while waiting on ch5
    tick(2);
    out_ready = 1'b0;
    pulse_start(8'b0010_0000);
    wait_valid("rst", 50);
    chk("rst_pre_s", int'(s), 5);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_now_valid", int'(out_valid), 0);
    chk("rst_now_s", int'(s), 0);
    chk("rst_now_ch", int'(out_ch), 0);
    chk("rst_now_data", int'(out_data), 0);
    chk("rst_now_busy", int'(busy), 0);
    chk("rst_now_done", int'(done), 0);
    d0 = done_cnt;
    tick(2);
    reset = 1'b0;
    tick(2);
    chk("rst_no_done", done_cnt - d0, 0);
    hs_log.delete();
    out_ready = 1'b1;
    pulse_start(8'b0110_0000);
    wait_done("post_rst", 50);
    e = '{5, 6};
    check_log("post_rst", e);

    tick(2);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/mux_8_1_scan_ctrl.md
Name: mux_8_1_scan_ctrl

Overview:
- Sequencer directly upstream of the 8:1, 3-bit mux (mux_8_1_case): drives its select s, waits a settle time, captures the mux output y and presents it with its channel index on a valid/ready stream.
- Scans a masked subset of the 8 inputs in ascending order, either single-pass or continuously.
- Turns the combinational mux into a time-multiplexed channel reader for downstream consumers.

Parameters:
- WIDTH, 3, data width of mux output y (matches mux d0..d7/y width).
- SETTLE_CYCLES, 2, clocks between s update and y sampling; legal range 1..15; 0 is illegal.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a scan; sampled only in IDLE.
- continuous  input  1  1 = wrap to lowest enabled channel after the last one; sampled at each end-of-pass.
- ch_mask  input  8  channel enable, bit i = input d_i; captured on accepted start.
- s  output  3  mux select, registered.
- y_in  input  WIDTH  mux output y.
- out_data  output  WIDTH  captured sample.
- out_ch  output  3  channel index of out_data.
- out_valid  output  1  out_data/out_ch valid.
- out_ready  input  1  consumer accepts when out_valid & out_ready.
- busy  output  1  high from accepted start until return to IDLE.
- done  output  1  one-cycle pulse at end of a non-continuous pass or on an empty-mask start.

Behaviour:
- Reset (async, any state): s=0, out_data=0, out_ch=0, out_valid=0, busy=0, done=0, mask register=0, settle counter=0, state=IDLE. Reset mid-scan aborts immediately with no done pulse.
- States: IDLE, SETTLE, WAIT.
- IDLE, start=1, ch_mask!=0:
  - mask_r<=ch_mask.
  - s<=lowest set bit index.
  - counter<=SETTLE_CYCLES-1, busy<=1, go SETTLE.
- IDLE, start=1, ch_mask==0: done<=1 for one cycle, busy stays 0, remain IDLE.
- SETTLE:
  - While counter!=0: decrement.
  - When counter==0: out_data<=y_in, out_ch<=s, out_valid<=1, go WAIT.
  - Latency: start sampled at edge N, y_in sampled at edge N+SETTLE_CYCLES, out_valid high after that edge.
- WAIT:
  - out_data, out_ch, out_valid and s hold stable until handshake; y_in changes are ignored.
  - On handshake: out_valid<=0 the same edge, and the next channel is selected:
    - Next enabled channel above s exists: s<=it, counter<=SETTLE_CYCLES-1, go SETTLE.
    - Else, continuous=1: s<=lowest enabled channel, go SETTLE.
    - Else: done<=1 (one cycle), busy<=0, go IDLE; s keeps last value.
- Throughput: out_valid is never high on two consecutive cycles for different samples; minimum 1+SETTLE_CYCLES clocks between accepted samples.
- start while busy is ignored. ch_mask changes after capture are ignored until the next start.
- Deasserting continuous mid-pass ends the scan at the next end-of-pass.
- Single-channel mask with continuous=1 reselects the same channel each pass; s is rewritten and settle is still applied.
- done and out_valid never assert in the same cycle. done is registered.

Test Plan:
- Directed setup for all scenarios: mux d_i = i, mux driven by s.
- Full scan: reset, ch_mask=8'hFF, continuous=0, out_ready=1, pulse start → 8 samples out_ch=0..7 with out_data=0..7, consecutive valids 3 clocks apart (SETTLE_CYCLES=2), done pulse after the 8th handshake, busy then 0.
- Sparse mask with backpressure: ch_mask=8'b1010_0100, out_ready held low 5 cycles on each sample → samples (2,2),(5,5),(7,7); out_data/out_ch stable while stalled; exactly 3 handshakes.
- Continuous wrap: ch_mask=8'b1000_0001, continuous=1 → 0,7,0,7,…; clear continuous during the ch7 sample → the pass ends after that ch7 handshake with done=1.
- Empty mask and busy start: start with ch_mask=0 → done=1 one cycle, busy=0, out_valid stays 0. During a scan, pulse start and change ch_mask → sequence unchanged.
- Async reset mid-WAIT: assert reset between clock edges with out_valid=1, s=5 → out_valid, s, out_ch, out_data, busy all 0 immediately, no done. After release, a new start scans from the lowest enabled channel.
